pll_lock_rst_seq: RTL and testbench
===================================

Name: pll_lock_rst_seq

Overview:
- Reset/lock sequencer immediately downstream of the Gowin PLL wrapper.
- Consumes the PLL `lock` output and drives the PLL `RESET` input.
- Generates the system reset for logic clocked by `clkout0`; that logic re-synchronises the reset locally.
- Runs on the free-running PLL input reference clock (`clkin`, 50 MHz), so the sequencer keeps working while the PLL is unlocked.

Parameters:
- RST_CYCLES, 16: cycles `pll_rst` is held high per reset pulse (>=1).
- LOCK_TIMEOUT, 500000: cycles to wait for lock after reset release before retrying (10 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before `sys_rst` is released.
- MAX_RETRIES, 15: lock timeouts tolerated before entering FAIL (<=15).

Ports:
- clkin  in  1  free-running reference clock, same net as the PLL clkin.
- rst  in  1  synchronous, active-high reset.
- pll_lock  in  1  PLL lock output; asynchronous to clkin.
- pll_rst  out  1  PLL RESET drive, active-high.
- sys_rst  out  1  active-high reset for the clkout0 domain.
- locked_ok  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  4  number of lock timeouts since rst.
- state  out  3  current state encoding.

Behaviour:
- Clock and reset: one clock, `clkin`. Reset `rst` is synchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values: pll_rst=1, sys_rst=1, locked_ok=0, fail=0, retry_cnt=0, state=PLL_RST, all internal counters=0, synchroniser flops=0.
- Lock synchroniser: `pll_lock` passes through a 2-flop synchroniser producing `lock_s`. Latency is 2 cycles. All decisions use `lock_s` only.
- One shared counter `cnt`, wide enough for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). It clears on every state change.
- State encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- PLL_RST:
  - Outputs: pll_rst=1, sys_rst=1.
  - When cnt==RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - Outputs: pll_rst=0, sys_rst=1.
  - If lock_s=1, go to STABLE.
  - Else, when cnt==LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRIES, go to FAIL;
    - otherwise increment retry_cnt and go to PLL_RST.
  - If lock_s rises on the timeout cycle, the lock wins: go to STABLE.
- STABLE:
  - Outputs: pll_rst=0, sys_rst=1.
  - If lock_s=0, go back to WAIT_LOCK. cnt restarts; no retry is counted.
  - When cnt==STABLE_CYCLES-1 with lock_s=1, go to RUN.
- RUN:
  - Outputs: sys_rst=0, locked_ok=1, pll_rst=0.
  - If lock_s=0 (lock loss), go to PLL_RST. sys_rst=1 and pll_rst=1 from the next cycle. retry_cnt is unchanged.
- FAIL:
  - Outputs: pll_rst=1, sys_rst=1, fail=1.
  - Terminal; leaves only on rst.
- retry_cnt saturates and never wraps; it is bounded by MAX_RETRIES by construction.
- rst asserted in any state (including mid-RUN) returns everything to reset values on the next edge.
- Glitch rule: a lock_s low pulse of a single cycle in RUN still triggers a full re-sequence. There is no filtering beyond the synchroniser.

Optional Feature:
- Macro: PLL_LOCK_LOSS_CNT_EN.
- When defined:
  - Adds output port `lock_loss_cnt  out  8`: count of RUN->PLL_RST transitions since rst.
  - Reset value 0; saturates at 255.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2):
- Normal lock:
  - Stimulus: release rst, raise pll_lock 3 cycles after pll_rst falls, hold it high.
  - Required: pll_rst high exactly 4 cycles; sys_rst falls exactly 2+8 cycles after the pll_lock rise edge (±1 for state entry); locked_ok=1; retry_cnt=0.
- Timeout then lock:
  - Stimulus: keep pll_lock=0 through the first WAIT_LOCK, then raise it.
  - Required: second 4-cycle pll_rst pulse after 20 cycles; retry_cnt=1; reaches RUN.
- Permanent failure:
  - Stimulus: pll_lock held 0.
  - Required: three pll_rst pulses (initial plus 2 retries), then state=4, fail=1, pll_rst=1 and sys_rst=1 held indefinitely; retry_cnt=2.
- Unstable lock:
  - Stimulus: in STABLE, drop pll_lock for 1 cycle at cnt=5.
  - Required: return to WAIT_LOCK, no retry increment, sys_rst stays 1; RUN reached 8 stable cycles after lock returns.
- Lock loss in RUN:
  - Stimulus: drop pll_lock for 1 cycle.
  - Required: sys_rst=1 and pll_rst=1 within 3 cycles, full re-sequence follows, retry_cnt unchanged; with PLL_LOCK_LOSS_CNT_EN, lock_loss_cnt=1.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during STABLE and during FAIL.
  - Required: next cycle state=0, pll_rst=1, sys_rst=1, fail=0, retry_cnt=0.

Source files
------------

// File: rtl/pll_lock_rst_seq.sv
// pll_lock_rst_seq: PLL reset/lock sequencer on clkin; optional lock-loss counter via PLL_LOCK_LOSS_CNT_EN
module pll_lock_rst_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 15
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       locked_ok,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
`ifdef PLL_LOCK_LOSS_CNT_EN
  , output logic [7:0] lock_loss_cnt
`endif
);
  localparam int MAXC = (RST_CYCLES > LOCK_TIMEOUT) ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
                                                   : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {PLL_RST = 3'd0, WAIT_LOCK = 3'd1, STABLE = 3'd2, RUN = 3'd3, FAIL = 3'd4} st_t;
  st_t st, nxt;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [3:0] retry_n;
  logic lock_s;
  assign lock_s = sync[1];
  assign state = st;
  // next state and retry accounting, driven only by the synchronised lock
  always_comb begin
    nxt = st;
    retry_n = retry_cnt;
    case (st)
      PLL_RST:   if (cnt == CW'(RST_CYCLES - 1)) nxt = WAIT_LOCK;
      WAIT_LOCK: if (lock_s) nxt = STABLE;
                 else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                   nxt = (retry_cnt == 4'(MAX_RETRIES)) ? FAIL : PLL_RST;
                   retry_n = (retry_cnt == 4'(MAX_RETRIES)) ? retry_cnt : retry_cnt + 4'd1;
                 end
      STABLE:    if (!lock_s) nxt = WAIT_LOCK;
                 else if (cnt == CW'(STABLE_CYCLES - 1)) nxt = RUN;
      RUN:       if (!lock_s) nxt = PLL_RST;
      FAIL:      nxt = FAIL;
      default:   nxt = PLL_RST;
    endcase
  end
  // state, shared counter, synchroniser and outputs registered from the next state
  always_ff @(posedge clkin) begin
    if (rst) begin
      st <= PLL_RST;
      cnt <= '0;
      sync <= '0;
      retry_cnt <= '0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      locked_ok <= 1'b0;
      fail <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= (nxt != st) ? '0 : (cnt == CW'(MAXC)) ? cnt : cnt + CW'(1);
      sync <= {sync[0], pll_lock};
      retry_cnt <= retry_n;
      pll_rst <= (nxt == PLL_RST) || (nxt == FAIL);
      sys_rst <= nxt != RUN;
      locked_ok <= nxt == RUN;
      fail <= nxt == FAIL;
    end
  end
`ifdef PLL_LOCK_LOSS_CNT_EN
  // saturating count of lock losses seen while running
  always_ff @(posedge clkin) begin
    if (rst) lock_loss_cnt <= '0;
    else if (st == RUN && !lock_s && lock_loss_cnt != 8'hff) lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// tb_pll_lock_rst_seq: scoreboard bench for pll_lock_rst_seq against a timer-based reference model
module tb_pll_lock_rst_seq;
  localparam int RC = 4, LT = 20, SC = 8, MR = 2;
  logic clk = 1'b0, rst = 1'b1, pll_lock = 1'b0;
  logic pll_rst, sys_rst, locked_ok, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;
  logic [7:0] loss_act;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
  assign loss_act = lock_loss_cnt;
`else
  assign loss_act = 8'd0;
`endif
  pll_lock_rst_seq #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)) dut (
    .clkin(clk), .rst(rst), .pll_lock(pll_lock), .pll_rst(pll_rst), .sys_rst(sys_rst),
    .locked_ok(locked_ok), .fail(fail), .retry_cnt(retry_cnt), .state(state)
`ifdef PLL_LOCK_LOSS_CNT_EN
    , .lock_loss_cnt(lock_loss_cnt)
`endif
  );
  always #5 clk = ~clk;
  logic [18:0] exp_q[$];
  int checks = 0, passed = 0;
  int ph = 0, el = 0, rc = 0, lc = 0;
  bit d1 = 0, d2 = 0;
  function automatic void model_step(bit r, bit l);
    int np;
    bit ls;
    if (r) begin
      ph = 0; el = 0; rc = 0; lc = 0; d1 = 0; d2 = 0;
    end else begin
      ls = d2;
      np = ph;
      if (ph == 0 && el + 1 == RC) np = 1;
      if (ph == 1 && ls) np = 2;
      if (ph == 1 && !ls && el + 1 == LT) begin
        if (rc >= MR) np = 4;
        else begin rc = rc + 1; np = 0; end
      end
      if (ph == 2 && !ls) np = 1;
      if (ph == 2 && ls && el + 1 == SC) np = 3;
      if (ph == 3 && !ls) begin np = 0; lc = (lc < 255) ? lc + 1 : 255; end
      el = (np != ph) ? 0 : el + 1;
      ph = np;
      d2 = d1;
      d1 = l;
    end
  endfunction
  function automatic logic [18:0] exp_vec();
    logic [7:0] e_lc;
    bit p;
`ifdef PLL_LOCK_LOSS_CNT_EN
    e_lc = 8'(lc);
`else
    e_lc = 8'd0;
`endif
    p = (ph == 0) || (ph == 4);
    return {3'(ph), 4'(rc), e_lc, ph == 4, ph == 3, ph != 3, p};
  endfunction
  task automatic cyc(input bit r, input bit l);
    @(negedge clk);
    rst = r;
    pll_lock = l;
    model_step(r, l);
    exp_q.push_back(exp_vec());
  endtask
  task automatic hold(input bit l, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, l);
  endtask
  // monitor: every edge after a stimulus step must match the head of the queue
  initial begin
    logic [18:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {state, retry_cnt, loss_act, fail, locked_ok, sys_rst, pll_rst};
        checks++;
        if (a === e) passed++;
        else $display("FAIL cycle_outputs t=%0t got st=%0d rc=%0d lc=%0d f=%b ok=%b sr=%b pr=%b want st=%0d rc=%0d lc=%0d f=%b ok=%b sr=%b pr=%b",
                      $time, a[18:16], a[15:12], a[11:4], a[3], a[2], a[1], a[0],
                      e[18:16], e[15:12], e[11:4], e[3], e[2], e[1], e[0]);
      end
    end
  end
  initial begin
    cyc(1, 0); cyc(1, 0);
    hold(0, RC + 3); hold(1, 40);
    cyc(1, 0);
    hold(0, RC + LT + RC + 3); hold(1, 40);
    cyc(1, 0);
    hold(0, 3 * (RC + LT) + 15);
    cyc(1, 0);
    hold(0, RC + 2); hold(1, 7); hold(0, 1); hold(1, 30);
    hold(0, 1); hold(1, 45);
    hold(0, 1); hold(1, 3);
    cyc(1, 1);
    hold(0, RC + LT - 3); hold(1, 30);
    cyc(1, 0);
    for (int k = 0; k < 150; k++) begin
      int len;
      bit lv;
      len = $urandom_range(1, 30);
      lv = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 25) == 0) cyc(1, lv);
      hold(lv, len);
    end
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL queue_drain left=%0d want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
